// File: rtl/spi_inst_pkg.sv
// Shared constants and types for the SPI instruction core: opcodes, storage sizes, parser states.
package spi_inst_pkg;

   localparam int WORD_W      = 16;
   localparam int FIFO_DEPTH  = 256;
   localparam int RAM_DEPTH   = 256;
   localparam int TIMEOUT_CLK = 4096;

   localparam logic [7:0] OP_EN   = 8'h01;
   localparam logic [7:0] OP_WREG = 8'h02;
   localparam logic [7:0] OP_RSUM = 8'h03;
   localparam logic [7:0] OP_FWR  = 8'h04;
   localparam logic [7:0] OP_FRD  = 8'h05;
   localparam logic [7:0] OP_MWR  = 8'h06;
   localparam logic [7:0] OP_MRD  = 8'h07;

   typedef enum logic [1:0] {IDLE, ARG, LEN, DATA} parser_state_t;
   typedef enum logic [1:0] {TX_ZERO, TX_HI, TX_LO} tx_mode_t;
   typedef enum logic [1:0] {SRC_SUM, SRC_FIFO, SRC_MEM} rd_src_t;

   // Opcodes that stay inert until the enable flag has been set.
   function automatic logic is_guarded_op(input logic [7:0] op);
      return (op >= OP_WREG) && (op <= OP_MRD);
   endfunction

endpackage

// File: rtl/spi_inst_core_if.sv
// SPI pin bundle between the MCU-side master and the FPGA command core, plus parser state for observation.
interface spi_inst_core_if;
   import spi_inst_pkg::*;

   // Plain SPI mode 0 pins; no valid/ready here, bytes are framed by spi_sel toggling per byte.
   logic          spi_scl;
   logic          spi_sdi;
   logic          spi_sel;
   logic          spi_sdo;
   parser_state_t dbg_state;

   modport master (output spi_scl, spi_sdi, spi_sel, input spi_sdo, dbg_state);
   modport slave  (input spi_scl, spi_sdi, spi_sel, output spi_sdo, dbg_state);

endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode 0 slave byte layer: input synchronizers, rx/tx shift registers, rx_valid pulse.
module spi_slave_byte #(
   parameter bit sim_present = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_scl,
   input  logic       spi_sdi,
   input  logic       spi_sel,
   output logic       spi_sdo,
   input  logic [7:0] tx_byte,
   output logic [7:0] rx_byte,
   output logic       rx_valid
);

   logic [1:0] scl_m, sdi_m, sel_m;
   logic       scl_s, sdi_s, sel_s;
   logic       scl_d, sel_d;
   logic       scl_rise, sel_rise;
   logic [7:0] rx_shift, tx_shift;
   logic [2:0] bit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_m <= 2'b00;
         sdi_m <= 2'b00;
         sel_m <= 2'b11;
         scl_d <= 1'b0;
         sel_d <= 1'b1;
      end else begin
         scl_m <= {scl_m[0], spi_scl};
         sdi_m <= {sdi_m[0], spi_sdi};
         sel_m <= {sel_m[0], spi_sel};
         scl_d <= scl_s;
         sel_d <= sel_s;
      end
   end

   assign scl_s    = sim_present ? scl_m[0] : scl_m[1];
   assign sdi_s    = sim_present ? sdi_m[0] : sdi_m[1];
   assign sel_s    = sim_present ? sel_m[0] : sel_m[1];
   assign scl_rise = scl_s & ~scl_d;
   assign sel_rise = sel_s & ~sel_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_shift <= 8'h00;
         rx_byte  <= 8'h00;
         rx_valid <= 1'b0;
         bit_cnt  <= 3'd0;
         tx_shift <= 8'h00;
      end else begin
         rx_valid <= 1'b0;
         if (sel_rise) begin
            bit_cnt <= 3'd0;
         end else if (scl_rise && !sel_s) begin
            rx_shift <= {rx_shift[6:0], sdi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_byte  <= {rx_shift[6:0], sdi_s};
               rx_valid <= 1'b1;
            end
         end
         // Reload while deselected so the first bit is on MISO before the first scl rise.
         if (sel_s)
            tx_shift <= tx_byte;
         else if (scl_rise)
            tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

   assign spi_sdo = ~sel_s & tx_shift[7];

endmodule

// File: rtl/spi_inst_core.sv
// SPI-slave command processor: opcode parser, 3 registers with sum readback, 256x16 FIFO and RAM.
// Optional macro INST_TIMEOUT_EN: abort a stalled command after 4096 clk without a byte.
module spi_inst_core
   import spi_inst_pkg::*;
#(
   parameter bit sim_present = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   spi_inst_core_if.slave spi
);

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic [7:0]        tx_byte;

   parser_state_t     state;
   tx_mode_t          tx_mode;
   rd_src_t           rd_src;
   logic [7:0]        op;
   logic [1:0]        idx;
   logic [7:0]        arg_byte;
   logic [7:0]        hi_byte;
   logic              hi_phase;
   logic [15:0]       len_cnt;
   logic [16:0]       addr;
   logic              en;
   logic [WORD_W-1:0] reg1, reg2, reg3, sum_q;
   logic [WORD_W-1:0] rd_word;
   logic              timeout;

   logic              push_req, pop_req;
   logic [WORD_W-1:0] push_data;
   logic [8:0]        wr_ptr, rd_ptr;
   logic              fifo_full, fifo_empty, fifo_zero;
   logic [WORD_W-1:0] fifo_q;
   logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];

   logic              ram_we, ram_re, ram_hit, ram_zero;
   logic [16:0]       ram_addr;
   logic [WORD_W-1:0] ram_wdata, ram_q;
   logic [WORD_W-1:0] ram_mem [RAM_DEPTH];

   spi_slave_byte #(.sim_present(sim_present)) u_byte (
      .clk      (clk),
      .rst      (rst),
      .spi_scl  (spi.spi_scl),
      .spi_sdi  (spi.spi_sdi),
      .spi_sel  (spi.spi_sel),
      .spi_sdo  (spi.spi_sdo),
      .tx_byte  (tx_byte),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid)
   );

   assign spi.dbg_state = state;

`ifdef INST_TIMEOUT_EN
   logic [11:0] stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= 12'd0;
      else if (rx_valid || state == IDLE)
         stall_cnt <= 12'd0;
      else if (stall_cnt != 12'(TIMEOUT_CLK - 1))
         stall_cnt <= stall_cnt + 12'd1;
   end

   assign timeout = (state != IDLE) && (stall_cnt == 12'(TIMEOUT_CLK - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tx_mode   <= TX_ZERO;
         rd_src    <= SRC_SUM;
         op        <= 8'h00;
         idx       <= 2'd0;
         arg_byte  <= 8'h00;
         hi_byte   <= 8'h00;
         hi_phase  <= 1'b1;
         len_cnt   <= 16'd0;
         addr      <= 17'd0;
         en        <= 1'b0;
         reg1      <= '0;
         reg2      <= '0;
         reg3      <= '0;
         sum_q     <= '0;
         push_req  <= 1'b0;
         push_data <= '0;
         pop_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         ram_addr  <= 17'd0;
         ram_wdata <= '0;
      end else begin
         push_req <= 1'b0;
         pop_req  <= 1'b0;
         ram_we   <= 1'b0;
         ram_re   <= 1'b0;
         if (rx_valid) begin
            case (state)
               IDLE: begin
                  op      <= rx_byte;
                  idx     <= 2'd0;
                  tx_mode <= TX_ZERO;
                  if (rx_byte == OP_EN) begin
                     en <= 1'b1;
                  end else if (en && is_guarded_op(rx_byte)) begin
                     case (rx_byte)
                        OP_RSUM: begin
                           state  <= ARG;
                           sum_q  <= reg1 + reg2 + reg3;
                           rd_src <= SRC_SUM;
                        end
                        OP_FWR, OP_FRD: state <= LEN;
                        default:        state <= ARG;
                     endcase
                  end
               end
               ARG: begin
                  idx <= idx + 2'd1;
                  case (op)
                     OP_WREG: begin
                        if (idx == 2'd0) begin
                           arg_byte <= rx_byte;
                        end else if (idx == 2'd1) begin
                           hi_byte <= rx_byte;
                        end else begin
                           case (arg_byte)
                              8'd1:    reg1 <= {hi_byte, rx_byte};
                              8'd2:    reg2 <= {hi_byte, rx_byte};
                              8'd3:    reg3 <= {hi_byte, rx_byte};
                              default: ;
                           endcase
                           state <= IDLE;
                        end
                     end
                     OP_RSUM: begin
                        if (idx == 2'd0) begin
                           tx_mode <= TX_HI;
                        end else if (idx == 2'd1) begin
                           tx_mode <= TX_LO;
                        end else begin
                           tx_mode <= TX_ZERO;
                           state   <= IDLE;
                        end
                     end
                     default: begin
                        if (idx == 2'd0) begin
                           hi_byte <= rx_byte;
                        end else begin
                           addr  <= {1'b0, hi_byte, rx_byte};
                           idx   <= 2'd0;
                           state <= LEN;
                        end
                     end
                  endcase
               end
               LEN: begin
                  if (idx == 2'd0) begin
                     hi_byte <= rx_byte;
                     idx     <= 2'd1;
                  end else begin
                     len_cnt  <= {hi_byte, rx_byte};
                     hi_phase <= 1'b1;
                     if ({hi_byte, rx_byte} == 16'd0) begin
                        state <= IDLE;
                     end else begin
                        state <= DATA;
                        // Read commands fetch their first word now so it is ready for the next byte.
                        if (op == OP_FRD) begin
                           pop_req <= 1'b1;
                           rd_src  <= SRC_FIFO;
                           tx_mode <= TX_HI;
                        end else if (op == OP_MRD) begin
                           ram_re   <= 1'b1;
                           ram_addr <= addr;
                           rd_src   <= SRC_MEM;
                           tx_mode  <= TX_HI;
                        end
                     end
                  end
               end
               DATA: begin
                  if (hi_phase) begin
                     hi_byte  <= rx_byte;
                     hi_phase <= 1'b0;
                     if (op == OP_FRD || op == OP_MRD)
                        tx_mode <= TX_LO;
                  end else begin
                     hi_phase <= 1'b1;
                     len_cnt  <= len_cnt - 16'd1;
                     addr     <= addr + 17'd1;
                     if (op == OP_FWR) begin
                        push_req  <= 1'b1;
                        push_data <= {hi_byte, rx_byte};
                     end
                     if (op == OP_MWR) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= {hi_byte, rx_byte};
                     end
                     if (len_cnt == 16'd1) begin
                        state   <= IDLE;
                        tx_mode <= TX_ZERO;
                     end else if (op == OP_FRD) begin
                        pop_req <= 1'b1;
                        tx_mode <= TX_HI;
                     end else if (op == OP_MRD) begin
                        ram_re   <= 1'b1;
                        ram_addr <= addr + 17'd1;
                        tx_mode  <= TX_HI;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (timeout) begin
            state    <= IDLE;
            tx_mode  <= TX_ZERO;
            hi_phase <= 1'b1;
         end
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[8] != rd_ptr[8]) && (wr_ptr[7:0] == rd_ptr[7:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= 9'd0;
         rd_ptr    <= 9'd0;
         fifo_zero <= 1'b1;
      end else begin
         if (push_req && !fifo_full)
            wr_ptr <= wr_ptr + 9'd1;
         if (pop_req) begin
            fifo_zero <= fifo_empty;
            if (!fifo_empty)
               rd_ptr <= rd_ptr + 9'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_req && !fifo_full)
         fifo_mem[wr_ptr[7:0]] <= push_data;
      if (pop_req)
         fifo_q <= fifo_mem[rd_ptr[7:0]];
   end

   assign ram_hit = (ram_addr < 17'(RAM_DEPTH));

   always_ff @(posedge clk) begin
      if (ram_we && ram_hit)
         ram_mem[ram_addr[7:0]] <= ram_wdata;
      if (ram_re)
         ram_q <= ram_mem[ram_addr[7:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ram_zero <= 1'b1;
      else if (ram_re)
         ram_zero <= ~ram_hit;
   end

   always_comb begin
      rd_word = sum_q;
      case (rd_src)
         SRC_FIFO: rd_word = fifo_zero ? '0 : fifo_q;
         SRC_MEM:  rd_word = ram_zero ? '0 : ram_q;
         default:  rd_word = sum_q;
      endcase
      tx_byte = 8'h00;
      case (tx_mode)
         TX_HI:   tx_byte = rd_word[15:8];
         TX_LO:   tx_byte = rd_word[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_spi_inst_core.sv
// Bench for spi_inst_core: SPI master driver pushes the expected MISO byte per transfer, a monitor compares.
module tb_spi_inst_core;
   import spi_inst_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   sent_count;
   int   mon_count;
   logic [7:0] exp_q[$];

   spi_inst_core_if spi();

   spi_inst_core #(.sim_present(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .spi (spi)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic send(input logic [7:0] b, input logic [7:0] exp_miso);
      exp_q.push_back(exp_miso);
      sent_count++;
      @(negedge clk);
      spi.spi_sel = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 7; i >= 0; i--) begin
         spi.spi_sdi = b[i];
         repeat (2) @(negedge clk);
         spi.spi_scl = 1'b1;
         repeat (2) @(negedge clk);
         spi.spi_scl = 1'b0;
      end
      @(negedge clk);
      spi.spi_sel = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic partial_byte(input int nbits);
      @(negedge clk);
      spi.spi_sel = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi.spi_sdi = 1'b1;
         repeat (2) @(negedge clk);
         spi.spi_scl = 1'b1;
         repeat (2) @(negedge clk);
         spi.spi_scl = 1'b0;
      end
      @(negedge clk);
      spi.spi_sel = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic wreg(input logic [7:0] a, input logic [15:0] d);
      send(OP_WREG, 8'h00);
      send(a, 8'h00);
      send(d[15:8], 8'h00);
      send(d[7:0], 8'h00);
   endtask

   task automatic rsum(input logic [15:0] s);
      send(OP_RSUM, 8'h00);
      send(8'h00, 8'h00);
      send(8'h00, s[15:8]);
      send(8'h00, s[7:0]);
   endtask

   task automatic header(input logic [7:0] opc, input logic [15:0] len);
      send(opc, 8'h00);
      send(len[15:8], 8'h00);
      send(len[7:0], 8'h00);
   endtask

   task automatic mem_header(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] len);
      send(opc, 8'h00);
      send(a[15:8], 8'h00);
      send(a[7:0], 8'h00);
      send(len[15:8], 8'h00);
      send(len[7:0], 8'h00);
   endtask

   task automatic write_word(input logic [15:0] w);
      send(w[15:8], 8'h00);
      send(w[7:0], 8'h00);
   endtask

   task automatic read_word(input logic [15:0] w);
      send(8'h00, w[15:8]);
      send(8'h00, w[7:0]);
   endtask

   // Scoreboard monitor: assembles each MISO byte and checks it against the queue head
   initial begin : monitor
      logic [7:0] sh;
      logic [7:0] exp;
      int nb;
      sh = 8'h00;
      nb = 0;
      forever begin
         @(posedge spi.spi_scl or posedge spi.spi_sel);
         if (spi.spi_sel === 1'b1) begin
            nb = 0;
         end else begin
            sh = {sh[6:0], spi.spi_sdo};
            nb++;
            if (nb == 8) begin
               nb = 0;
               mon_count++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL miso_unexpected byte %0d got %02h with no expectation", mon_count, sh);
               end else begin
                  exp = exp_q.pop_front();
                  if (sh !== exp) begin
                     errors++;
                     $display("FAIL miso byte %0d got %02h expected %02h", mon_count, sh, exp);
                  end
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [15:0] w;
      checks     = 0;
      errors     = 0;
      sent_count = 0;
      mon_count  = 0;
      rst         = 1'b1;
      spi.spi_scl = 1'b0;
      spi.spi_sdi = 1'b0;
      spi.spi_sel = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      checks++;
      if (spi.spi_sdo !== 1'b0) begin
         errors++;
         $display("FAIL reset_sdo got %b expected 0", spi.spi_sdo);
      end
      checks++;
      if (spi.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state got %0d expected %0d", spi.dbg_state, IDLE);
      end

      // Before enable: these writes must not land (the 0x01 inside the second frame enables)
      wreg(8'h02, 16'h5678);
      wreg(8'h01, 16'h1234);
      rsum(16'h0000);

      send(OP_EN, 8'h00);
      wreg(8'h01, 16'h1234);
      rsum(16'h1234);

      // Sum wraps modulo 2^16; out-of-range register addresses are discarded
      wreg(8'h01, 16'hFFFF);
      wreg(8'h02, 16'h0002);
      wreg(8'h03, 16'h0001);
      rsum(16'h0002);
      wreg(8'h00, 16'hABCD);
      wreg(8'h05, 16'hABCD);
      wreg(8'h83, 16'hABCD);
      rsum(16'h0002);

      // Aborted partial byte must not shift framing
      partial_byte(3);
      rsum(16'h0002);

`ifdef INST_TIMEOUT_EN
      send(OP_WREG, 8'h00);
      send(8'h01, 8'h00);
      repeat (5000) @(negedge clk);
      rsum(16'h0002);
`endif

      // FIFO: 258 pushes, only 256 fit; read 258 back
      header(OP_FWR, 16'd258);
      for (int i = 0; i < 258; i++) write_word(16'(1000 + i));
      header(OP_FRD, 16'd258);
      for (int i = 0; i < 258; i++) begin
         w = (i < 256) ? 16'(1000 + i) : 16'h0000;
         read_word(w);
      end
      header(OP_FRD, 16'd1);
      read_word(16'h0000);
      header(OP_FWR, 16'd2);
      write_word(16'hBEEF);
      write_word(16'h1234);
      header(OP_FRD, 16'd2);
      read_word(16'hBEEF);
      read_word(16'h1234);
      header(OP_FRD, 16'd0);
      rsum(16'h0002);

      // RAM: writes at 240..259, only 240..255 exist
      mem_header(OP_MWR, 16'h00F0, 16'd20);
      for (int i = 0; i < 20; i++) write_word(16'(16'h5000 + i));
      mem_header(OP_MRD, 16'h00F0, 16'd20);
      for (int i = 0; i < 20; i++) begin
         w = (i < 16) ? 16'(16'h5000 + i) : 16'h0000;
         read_word(w);
      end
      mem_header(OP_MRD, 16'h00FE, 16'd4);
      read_word(16'h500E);
      read_word(16'h500F);
      read_word(16'h0000);
      read_word(16'h0000);
      mem_header(OP_MWR, 16'h0000, 16'd3);
      write_word(16'hA000);
      write_word(16'hA001);
      write_word(16'hA002);
      mem_header(OP_MRD, 16'h0000, 16'd3);
      read_word(16'hA000);
      read_word(16'hA001);
      read_word(16'hA002);
      mem_header(OP_MRD, 16'h0000, 16'd0);
      rsum(16'h0002);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      checks++;
      if (mon_count != sent_count) begin
         errors++;
         $display("FAIL byte_count got %0d expected %0d", mon_count, sent_count);
      end
      checks++;
      if (spi.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL final_state got %0d expected %0d", spi.dbg_state, IDLE);
      end

      // Final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
